// File: rtl/rf_pkg.sv
// rf_pkg: shared register file defaults and address range helper
package rf_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF = 8;
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction
endpackage

// File: rtl/rf_row.sv
// rf_row: one storage row with write enable and synchronous clear
module rf_row #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : we ? d : q;
endmodule

// File: rtl/rf_nxm_2r1w.sv
// rf_nxm_2r1w: DEPTH x DATA_W register file, one write port, two registered read ports
module rf_nxm_2r1w import rf_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrVal,
  input  logic              rdEnA,
  input  logic [ADDR_W-1:0] rdAddrA,
  output logic [DATA_W-1:0] rdValA,
  output logic              rdVldA,
  input  logic              rdEnB,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic [DATA_W-1:0] rdValB,
  output logic              rdVldB
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic [DATA_W-1:0] rd_a, rd_b;
  assign wr_ok = wrEn && addr_in_range(32'(wrAddr), DEPTH) && !(ZERO_REG != 0 && wrAddr == '0);
  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    rf_row #(.DATA_W(DATA_W)) u_row (
      .clk (clk),
      .rst (rst),
      .we  (wr_ok && wrAddr == ADDR_W'(i)),
      .d   (wrVal),
      .q   (mem[i])
    );
  end
  function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] a);
    return (!addr_in_range(32'(a), DEPTH) || (ZERO_REG != 0 && a == '0)) ? '0 :
           (BYPASS != 0 && wr_ok && wrAddr == a) ? wrVal : mem[a];
  endfunction
  always_comb begin
    rd_a = rd_mux(rdAddrA);
    rd_b = rd_mux(rdAddrB);
  end
  always_ff @(posedge clk) begin
    rdVldA <= !rst && rdEnA;
    rdVldB <= !rst && rdEnB;
    rdValA <= rst ? '0 : rdEnA ? rd_a : rdValA;
    rdValB <= rst ? '0 : rdEnB ? rd_b : rdValB;
  end
endmodule

// File: tb/tb_rf_nxm_2r1w.sv
// tb_rf_nxm_2r1w: scoreboard bench driving a default build and a DEPTH=6/ZERO_REG/no-bypass build
module tb_rf_nxm_2r1w;
  typedef struct packed {
    logic       va;
    logic       vb;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
  } exp_t;
  logic       clk = 0;
  logic       rst = 0;
  logic       wr_en = 0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_val = '0;
  logic       en_a = 0;
  logic [2:0] addr_a = '0;
  logic       en_b = 0;
  logic [2:0] addr_b = '0;
  logic [3:0] val_a0, val_b0, val_a1, val_b1;
  logic       vld_a0, vld_b0, vld_a1, vld_b1;
  exp_t       q[$];
  int         n_vec = 0;
  int         n_err = 0;
  always #5 clk = ~clk;
  rf_nxm_2r1w u_dut0 (
    .clk(clk), .rst(rst), .wrEn(wr_en), .wrAddr(wr_addr), .wrVal(wr_val),
    .rdEnA(en_a), .rdAddrA(addr_a), .rdValA(val_a0), .rdVldA(vld_a0),
    .rdEnB(en_b), .rdAddrB(addr_b), .rdValB(val_b0), .rdVldB(vld_b0)
  );
  rf_nxm_2r1w #(.DATA_W(4), .DEPTH(6), .BYPASS(0), .ZERO_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .wrEn(wr_en), .wrAddr(wr_addr), .wrVal(wr_val),
    .rdEnA(en_a), .rdAddrA(addr_a), .rdValA(val_a1), .rdVldA(vld_a1),
    .rdEnB(en_b), .rdAddrB(addr_b), .rdValB(val_b1), .rdVldB(vld_b1)
  );
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("vldA0", {3'b0, vld_a0}, {3'b0, e.va});
      chk("vldB0", {3'b0, vld_b0}, {3'b0, e.vb});
      chk("vldA1", {3'b0, vld_a1}, {3'b0, e.va});
      chk("vldB1", {3'b0, vld_b1}, {3'b0, e.vb});
      chk("valA0", val_a0, e.a0);
      chk("valB0", val_b0, e.b0);
      chk("valA1", val_a1, e.a1);
      chk("valB1", val_b1, e.b1);
    end
  end
  task automatic step(
    input logic r, input logic we, input logic [2:0] wa, input logic [3:0] wv,
    input logic ea, input logic [2:0] ra, input logic eb, input logic [2:0] rb,
    input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] a1, input logic [3:0] b1
  );
    rst = r; wr_en = we; wr_addr = wa; wr_val = wv;
    en_a = ea; addr_a = ra; en_b = eb; addr_b = rb;
    q.push_back('{va: ea && !r, vb: eb && !r, a0: a0, b0: b0, a1: a1, b1: b1});
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    step(1, 1, 3'd1, 4'hA, 1, 3'd1, 1, 3'd1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++)
      step(0, 1, 3'(i), 4'hA, 0, 3'd0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(0, 0, 3'd0, 4'h0, 1, 3'd7, 1, 3'd0, 4'hA, 4'hA, 4'h0, 4'h0);
    step(1, 1, 3'd3, 4'h5, 1, 3'd3, 0, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++)
      step(0, 0, 3'd0, 4'h0, 1, 3'(i), 1, 3'(7 - i), 4'h0, 4'h0, 4'h0, 4'h0);
    step(0, 1, 3'd3, 4'h5, 0, 3'd0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(0, 1, 3'd6, 4'hC, 0, 3'd0, 0, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    step(0, 0, 3'd0, 4'h0, 1, 3'd3, 1, 3'd6, 4'h5, 4'hC, 4'h5, 4'h0);
    step(0, 1, 3'd2, 4'h1, 0, 3'd0, 0, 3'd0, 4'h5, 4'hC, 4'h5, 4'h0);
    step(0, 1, 3'd2, 4'h9, 1, 3'd2, 1, 3'd2, 4'h9, 4'h9, 4'h1, 4'h1);
    step(0, 0, 3'd0, 4'h0, 1, 3'd2, 1, 3'd0, 4'h9, 4'h0, 4'h9, 4'h0);
    step(0, 0, 3'd0, 4'h0, 1, 3'd3, 0, 3'd0, 4'h5, 4'h0, 4'h5, 4'h0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 3'd0, 4'h0, 0, 3'd3, 0, 3'd0, 4'h5, 4'h0, 4'h5, 4'h0);
    step(0, 1, 3'd0, 4'hF, 1, 3'd0, 1, 3'd7, 4'hF, 4'h0, 4'h0, 4'h0);
    step(0, 1, 3'd7, 4'hF, 1, 3'd7, 1, 3'd0, 4'hF, 4'hF, 4'h0, 4'h0);
    step(0, 1, 3'd5, 4'h6, 1, 3'd5, 1, 3'd4, 4'h6, 4'h0, 4'h0, 4'h0);
    step(0, 0, 3'd0, 4'h0, 1, 3'd5, 1, 3'd1, 4'h6, 4'h0, 4'h6, 4'h0);
    step(1, 1, 3'd5, 4'h3, 1, 3'd5, 1, 3'd5, 4'h0, 4'h0, 4'h0, 4'h0);
    step(0, 0, 3'd0, 4'h0, 1, 3'd5, 1, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
